// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display arbiter: FSM encoding, digit
// geometry and the double-dabble add-3 correction helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Pre-shift correction: a digit that would reach 10+ after doubling gets +3.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= ADD3_THRESH) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add-3 correction on every digit, then shift the
// accumulator left by one bit, inserting the next binary bit at the bottom.
// The bit leaving the top digit is reported so the caller can flag overflow.
module bcd_dd_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGIT_W*DIGITS-1:0] accum_in,
  input  logic                      bit_in,
  output logic [DIGIT_W*DIGITS-1:0] accum_out,
  output logic                      carry_out
);

  logic [DIGIT_W*DIGITS-1:0] adj_s;

  // Correct each digit, then shift the whole accumulator by one bit.
  always_comb begin
    adj_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj_s[k*DIGIT_W +: DIGIT_W] = add3(accum_in[k*DIGIT_W +: DIGIT_W]);
    end
    accum_out = {adj_s[DIGIT_W*DIGITS-2:0], bit_in};
    carry_out = adj_s[DIGIT_W*DIGITS-1];
  end

endmodule

// File: rtl/bcd_display_arbiter.sv
// Round-robin arbiter sharing one sequential binary-to-BCD converter between
// N_REQ sources. A granted value is captured, converted one bit per clock,
// and published with sign, overflow and source id behind a one-cycle valid.
module bcd_display_arbiter
  import bcd_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int WIDTH  = 32,
  parameter  int DIGITS = 4,
  localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   val,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic                     valid,
  output logic [DIGIT_W*DIGITS-1:0] digits,
  output logic                     neg,
  output logic                     ovf,
  output logic [SRC_W-1:0]         src
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [N_REQ-1:0]  ACK_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  VAL_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SRC_W-1:0]  RR_RESET  = SRC_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t                    state_r;
  state_t                    state_s;
  logic [SRC_W-1:0]          rr_r;
  logic                      grant_found_s;
  logic [SRC_W-1:0]          grant_idx_s;
  logic [WIDTH-1:0]          cap_val_s;
  logic [WIDTH-1:0]          mag_r;
  logic [DIGIT_W*DIGITS-1:0] accum_r;
  logic                      ovf_acc_r;
  logic                      neg_cap_r;
  logic [SRC_W-1:0]          src_cap_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [DIGIT_W*DIGITS-1:0] step_accum_s;
  logic                      step_carry_s;
  logic [N_REQ-1:0]          ack_r;
  logic                      busy_r;
  logic                      valid_r;
  logic [DIGIT_W*DIGITS-1:0] digits_r;
  logic                      neg_r;
  logic                      ovf_r;
  logic [SRC_W-1:0]          src_r;

  assign ack    = ack_r;
  assign busy   = busy_r;
  assign valid  = valid_r;
  assign digits = digits_r;
  assign neg    = neg_r;
  assign ovf    = ovf_r;
  assign src    = src_r;

  bcd_dd_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .accum_in  (accum_r),
    .bit_in    (mag_r[WIDTH-1]),
    .accum_out (step_accum_s),
    .carry_out (step_carry_s)
  );

  // Round-robin search: first asserted request after the last granted index.
  always_comb begin : arb_comb
    int               cand;
    logic [SRC_W-1:0] idx;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand          = 0;
    idx           = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = (int'(rr_r) + off) % N_REQ;
      idx  = SRC_W'(cand);
      if (!grant_found_s && req[idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = idx;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    cap_val_s = val[int'(grant_idx_s)*WIDTH +: WIDTH];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: capture on a grant, shift WIDTH times, publish once.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == '0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: capture, iterate the converter, and register the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r      <= RR_RESET;
      mag_r     <= '0;
      accum_r   <= '0;
      ovf_acc_r <= 1'b0;
      neg_cap_r <= 1'b0;
      src_cap_r <= '0;
      cnt_r     <= '0;
      ack_r     <= '0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      digits_r  <= '0;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      src_r     <= '0;
    end else begin
      ack_r   <= '0;
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            neg_cap_r <= cap_val_s[WIDTH-1];
            // Unsigned magnitude: the most negative value maps to 2^(WIDTH-1).
            mag_r     <= cap_val_s[WIDTH-1] ? (~cap_val_s + VAL_ONE) : cap_val_s;
            accum_r   <= '0;
            ovf_acc_r <= 1'b0;
            cnt_r     <= CNT_LOAD;
            src_cap_r <= grant_idx_s;
            rr_r      <= grant_idx_s;
            ack_r     <= ACK_ONE << grant_idx_s;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          accum_r   <= step_accum_s;
          mag_r     <= {mag_r[WIDTH-2:0], 1'b0};
          ovf_acc_r <= ovf_acc_r | step_carry_s;
          cnt_r     <= cnt_r - CNT_ONE;
        end
        ST_DONE: begin
          digits_r <= accum_r;
          neg_r    <= neg_cap_r;
          ovf_r    <= ovf_acc_r;
          src_r    <= src_cap_r;
          valid_r  <= 1'b1;
          busy_r   <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
